fp32_divider: RTL

- Iterative IEEE-754 single-precision divider (a_in / b_in) for the FP execution unit.
- Companion to the pipelined FP32 multiplier. It keeps the same start/done/result/Exception contract so the FP reservation station can issue to either unit.
- Uses a restoring mantissa divider, one quotient bit per cycle, with round-to-nearest-even.
- Subnormals flush to zero. The block is not pipelined: busy blocks issue while an operation is in flight.

---
 rtl/fp32_divider.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/fp32_divider.sv
// fp32_divider: iterative IEEE-754 single-precision divider (a_in / b_in).
// Restoring mantissa division, one quotient bit per cycle, round-to-nearest-even.
// Subnormal operands and results flush to zero. Not pipelined.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      operation request, sampled only while busy=0
//   a_in       dividend, FP32
//   b_in       divisor, FP32
//   result     quotient, FP32, held until the next completion
//   busy       high while a division is in flight
//   done       one-cycle pulse when result/Exception are valid
//   Exception  overflow, underflow, divide-by-zero or invalid; qualified by done
//
// state  | meaning
// IDLE   | waiting for start; special-case operands resolved here
// DIVIDE | one restoring quotient bit per cycle, QBITS cycles
// ROUND  | normalise, round to nearest even, range-check, raise done

module fp32_divider #(
   parameter int EXP_BIAS = 127,
   parameter int QBITS    = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic [31:0] result,
   output logic        busy,
   output logic        done,
   output logic        Exception
);

   typedef enum logic [1:0] {IDLE, DIVIDE, ROUND} state_t;

   state_t              state_q, state_d;
   logic                sign_q, sign_d;
   logic signed [9:0]   exp_q, exp_d;
   logic [23:0]         div_q, div_d;
   logic [24:0]         rem_q, rem_d;
   logic [QBITS-1:0]    q_q, q_d;
   logic [4:0]          cnt_q, cnt_d;
   logic [31:0]         result_d;
   logic                exc_d, done_d;
   // special-case results are staged one cycle so done rises one edge after start
   logic                sp_pend_q, sp_pend_d;
   logic [31:0]         sp_res_q, sp_res_d;
   logic                sp_exc_q, sp_exc_d;

   logic [7:0]  ea, eb;
   logic [22:0] ma, mb;
   logic        a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, op_sign;

   assign ea      = a_in[30:23];
   assign eb      = b_in[30:23];
   assign ma      = a_in[22:0];
   assign mb      = b_in[22:0];
   assign op_sign = a_in[31] ^ b_in[31];
   assign a_zero  = (ea == 8'h00);
   assign b_zero  = (eb == 8'h00);
   assign a_nan   = (ea == 8'hFF) && (ma != 23'd0);
   assign b_nan   = (eb == 8'hFF) && (mb != 23'd0);
   assign a_inf   = (ea == 8'hFF) && (ma == 23'd0);
   assign b_inf   = (eb == 8'hFF) && (mb == 23'd0);

   assign busy = (state_q != IDLE);

   logic        rem_ge;
   logic [23:0] rem_sub;

   assign rem_ge  = (rem_q >= {1'b0, div_q});
   // when rem >= div the difference is below div, so 24 bits hold it
   assign rem_sub = rem_q[23:0] - div_q;

   logic [23:0]       rnd_mant;
   logic              rnd_guard, rnd_sticky, rnd_up;
   logic [24:0]       rnd_mant25;
   logic [22:0]       rnd_frac;
   logic signed [9:0] rnd_exp;
   logic [31:0]       rnd_res;
   logic              rnd_exc;

   always_comb begin
      rnd_mant   = 24'd0;
      rnd_guard  = 1'b0;
      rnd_sticky = 1'b0;
      rnd_exp    = exp_q;
      rnd_res    = 32'd0;
      rnd_exc    = 1'b0;
      if (q_q[QBITS-1]) begin
         rnd_mant   = q_q[QBITS-1 -: 24];
         rnd_guard  = q_q[1];
         rnd_sticky = q_q[0] | (rem_q != 25'd0);
      end else begin
         rnd_mant   = q_q[QBITS-2 -: 24];
         rnd_guard  = q_q[0];
         rnd_sticky = (rem_q != 25'd0);
         rnd_exp    = exp_q - 10'sd1;
      end
      rnd_up     = rnd_guard & (rnd_sticky | rnd_mant[0]);
      rnd_mant25 = {1'b0, rnd_mant} + {24'd0, rnd_up};
      if (rnd_mant25[24]) begin
         rnd_frac = rnd_mant25[23:1];
         rnd_exp  = rnd_exp + 10'sd1;
      end else begin
         rnd_frac = rnd_mant25[22:0];
      end
      if (rnd_exp >= 10'sd255) begin
         rnd_res = {sign_q, 8'hFF, 23'd0};
         rnd_exc = 1'b1;
      end else if (rnd_exp <= 10'sd0) begin
         rnd_res = {sign_q, 31'd0};
         rnd_exc = 1'b1;
      end else begin
         rnd_res = {sign_q, rnd_exp[7:0], rnd_frac};
         rnd_exc = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      div_d     = div_q;
      rem_d     = rem_q;
      q_d       = q_q;
      cnt_d     = cnt_q;
      result_d  = result;
      exc_d     = Exception;
      done_d    = 1'b0;
      sp_pend_d = 1'b0;
      sp_res_d  = sp_res_q;
      sp_exc_d  = sp_exc_q;
      case (state_q)
         IDLE: begin
            if (sp_pend_q) begin
               result_d = sp_res_q;
               exc_d    = sp_exc_q;
               done_d   = 1'b1;
            end
            if (start) begin
               if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                  sp_pend_d = 1'b1;
                  sp_res_d  = 32'h7FC0_0000;
                  sp_exc_d  = 1'b1;
               end else if (b_zero) begin
                  sp_pend_d = 1'b1;
                  sp_res_d  = {op_sign, 8'hFF, 23'd0};
                  sp_exc_d  = 1'b1;
               end else if (a_inf) begin
                  sp_pend_d = 1'b1;
                  sp_res_d  = {op_sign, 8'hFF, 23'd0};
                  sp_exc_d  = 1'b0;
               end else if (a_zero || b_inf) begin
                  sp_pend_d = 1'b1;
                  sp_res_d  = {op_sign, 31'd0};
                  sp_exc_d  = 1'b0;
               end else begin
                  sign_d  = op_sign;
                  exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb})
                            + $signed(10'(EXP_BIAS));
                  div_d   = {1'b1, mb};
                  rem_d   = {2'b01, ma};
                  q_d     = '0;
                  cnt_d   = 5'd0;
                  state_d = DIVIDE;
               end
            end
         end
         DIVIDE: begin
            q_d   = {q_q[QBITS-2:0], rem_ge};
            rem_d = rem_ge ? {rem_sub, 1'b0} : {rem_q[23:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(QBITS-1)) state_d = ROUND;
         end
         ROUND: begin
            result_d = rnd_res;
            exc_d    = rnd_exc;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         div_q     <= '0;
         rem_q     <= '0;
         q_q       <= '0;
         cnt_q     <= '0;
         result    <= '0;
         Exception <= 1'b0;
         done      <= 1'b0;
         sp_pend_q <= 1'b0;
         sp_res_q  <= '0;
         sp_exc_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         div_q     <= div_d;
         rem_q     <= rem_d;
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         result    <= result_d;
         Exception <= exc_d;
         done      <= done_d;
         sp_pend_q <= sp_pend_d;
         sp_res_q  <= sp_res_d;
         sp_exc_q  <= sp_exc_d;
      end
   end

endmodule
